// File: rtl/button_event_pkg.sv
// ---------------------------------------------------------------------------
// button_event_pkg
//
// Shared definitions for the button event block:
//   state_t      - per-channel FSM state (IDLE / PRESSED / HELD)
//   CH_*         - channel index of each debounced input in the clean bus
//   CNT_W        - width of the hold and repeat tick counters
//   sat_inc()    - saturating increment used by the tick counters
// ---------------------------------------------------------------------------
package button_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    localparam int CH_REPROGRAM   = 0;
    localparam int CH_DOOR_DRIVER = 1;
    localparam int CH_DOOR_PASS   = 2;
    localparam int CH_IGNITION    = 3;
    localparam int CH_HIDDEN_SW   = 4;
    localparam int CH_BRAKE       = 5;

    localparam int CNT_W = 16;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/button_event_channel.sv
// ---------------------------------------------------------------------------
// button_event_channel
//
// One channel of the button event block: edge detection on a debounced
// level plus the IDLE -> PRESSED -> HELD state machine that measures how
// long the level stays high.
//
// Optional feature: when BUTTON_EVENT_REPEAT_EN is defined, a second
// counter produces an auto-repeat pulse every REPEAT_MS ticks while HELD.
// With the macro undefined, auto_repeat is tied low and no repeat counter
// exists.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous, active-high reset
//   clean        in   debounced level, 1 = pressed
//   tick         in   1 ms strobe from the shared prescaler
//   pressed      out  one-cycle pulse on a rising edge of clean
//   released     out  one-cycle pulse on a falling edge of clean
//   long_press   out  one-cycle pulse after HOLD_MS ticks of continuous high
//   auto_repeat  out  one-cycle pulse every REPEAT_MS ticks while HELD
//   held         out  level, 1 while the FSM is in HELD
//   state        out  current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module button_event_channel
    import button_event_pkg::*;
#(
    parameter int HOLD_MS = 1000
`ifdef BUTTON_EVENT_REPEAT_EN
    ,
    parameter int REPEAT_MS = 200
`endif
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   clean,
    input  logic   tick,
    output logic   pressed,
    output logic   released,
    output logic   long_press,
    output logic   auto_repeat,
    output logic   held,
    output state_t state
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MS);

    logic             prev;
    logic [CNT_W-1:0] hold_cnt;
    logic             rise;
    logic             fall;

    assign rise = clean & ~prev;
    assign fall = ~clean & prev;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LIM = CNT_W'(REPEAT_MS);

    logic [CNT_W-1:0] rep_cnt;
`else
    assign auto_repeat = 1'b0;
`endif

    // Valid/ready does not apply here: every output is a registered
    // one-cycle strobe (or the held level), produced unconditionally and
    // never back-pressured by the consumer.
    always_ff @(posedge clock) begin
        if (reset) begin
            // Capturing the current level means a button already down at
            // reset is not reported as a fresh press.
            prev       <= clean;
            pressed    <= 1'b0;
            released   <= 1'b0;
            long_press <= 1'b0;
            held       <= 1'b0;
            hold_cnt   <= '0;
            state      <= ST_IDLE;
`ifdef BUTTON_EVENT_REPEAT_EN
            auto_repeat <= 1'b0;
            rep_cnt     <= '0;
`endif
        end else begin
            prev       <= clean;
            pressed    <= rise;
            released   <= fall;
            long_press <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            auto_repeat <= 1'b0;
`endif
            if (fall) begin
                // A fall wins over any tick arriving in the same cycle.
                state    <= ST_IDLE;
                held     <= 1'b0;
                hold_cnt <= '0;
`ifdef BUTTON_EVENT_REPEAT_EN
                rep_cnt  <= '0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        held <= 1'b0;
                        if (rise) begin
                            state    <= ST_PRESSED;
                            hold_cnt <= '0;
                        end
                    end

                    ST_PRESSED: begin
                        held <= 1'b0;
                        // The tick is free-running, so the first counted
                        // tick can land anywhere within the first 1 ms.
                        if (tick && clean) begin
                            if (sat_inc(hold_cnt) == HOLD_LIM) begin
                                long_press <= 1'b1;
                                held       <= 1'b1;
                                state      <= ST_HELD;
                                hold_cnt   <= '0;
`ifdef BUTTON_EVENT_REPEAT_EN
                                rep_cnt    <= '0;
`endif
                            end else begin
                                hold_cnt <= sat_inc(hold_cnt);
                            end
                        end
                    end

                    ST_HELD: begin
                        held <= 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
                        if (tick) begin
                            if (sat_inc(rep_cnt) == REP_LIM) begin
                                auto_repeat <= 1'b1;
                                rep_cnt     <= '0;
                            end else begin
                                rep_cnt <= sat_inc(rep_cnt);
                            end
                        end
`endif
                    end

                    default: begin
                        // Unused encoding: recover to a known state.
                        state    <= ST_IDLE;
                        held     <= 1'b0;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/button_event.sv
// ---------------------------------------------------------------------------
// button_event
//
// Turns N debounced level inputs into single-cycle press, release and
// long-press events for the alarm FSM. A shared prescaler produces a 1 ms
// tick; each channel is an independent button_event_channel instance.
//
// Optional feature macro: BUTTON_EVENT_REPEAT_EN enables the per-channel
// auto-repeat pulse while a button is HELD. Without it auto_repeat is 0.
//
// Ports:
//   clock        in   system clock (CLK_HZ)
//   reset        in   synchronous, active-high reset
//   clean        in   [N]   debounced levels, 1 = pressed/active
//   pressed      out  [N]   one-cycle pulse on a rising edge of clean[i]
//   released     out  [N]   one-cycle pulse on a falling edge of clean[i]
//   long_press   out  [N]   one-cycle pulse after clean[i] stays high HOLD_MS
//   auto_repeat  out  [N]   one-cycle auto-repeat pulse (optional feature)
//   held         out  [N]   level, 1 while channel i is in HELD
//   state        out  [2N]  per-channel FSM state, channel i at [2i+1:2i]
// ---------------------------------------------------------------------------
module button_event
    import button_event_pkg::*;
#(
    parameter int N         = 6,
    parameter int CLK_HZ    = 100_000_000,
    parameter int HOLD_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   clean,
    output logic [N-1:0]   pressed,
    output logic [N-1:0]   released,
    output logic [N-1:0]   long_press,
    output logic [N-1:0]   auto_repeat,
    output logic [N-1:0]   held,
    output logic [2*N-1:0] state
);

    localparam int DIV = CLK_HZ / 1000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    if ((CLK_HZ % 1000) != 0 || DIV < 1 ||
        HOLD_MS < 1 || HOLD_MS > 65535 ||
        REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_bad_cfg
        $error("button_event: unsupported parameter set");
    end

    logic [PW-1:0] presc;
    logic          tick;

    // Tick is high in the last cycle of each 1 ms window, i.e. the cycle
    // in which the prescaler wraps back to zero.
    assign tick = (presc == PW'(DIV - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t ch_state;

        button_event_channel #(
            .HOLD_MS   (HOLD_MS)
`ifdef BUTTON_EVENT_REPEAT_EN
            ,
            .REPEAT_MS (REPEAT_MS)
`endif
        ) u_ch (
            .clock       (clock),
            .reset       (reset),
            .clean       (clean[i]),
            .tick        (tick),
            .pressed     (pressed[i]),
            .released    (released[i]),
            .long_press  (long_press[i]),
            .auto_repeat (auto_repeat[i]),
            .held        (held[i]),
            .state       (ch_state)
        );

        assign state[2*i +: 2] = ch_state;
    end

endmodule

// File: tb/tb_button_event.sv
`timescale 1ns/1ps
module tb_button_event;
  localparam int N         = 6;
  localparam int CLK_HZ    = 10_000;
  localparam int HOLD_MS   = 5;
  localparam int REPEAT_MS = 2;
  localparam int DIV       = CLK_HZ / 1000;
  localparam int VW        = 5 * N;

  // ---------------- clock / reset ----------------
  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   clean = '0;
  logic [N-1:0]   pressed, released, long_press, auto_repeat, held;
  logic [2*N-1:0] state;

  always #5 clock = ~clock;

  button_event #(
    .N         (N),
    .CLK_HZ    (CLK_HZ),
    .HOLD_MS   (HOLD_MS),
    .REPEAT_MS (REPEAT_MS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .clean       (clean),
    .pressed     (pressed),
    .released    (released),
    .long_press  (long_press),
    .auto_repeat (auto_repeat),
    .held        (held),
    .state       (state)
  );

  // ---------------- scoreboard ----------------
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] exp_cur;
  logic [VW-1:0] obs;
  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  assign obs = {pressed, released, long_press, held, auto_repeat};

  // Reference model: time is measured in elapsed 1 ms ticks. A press
  // records the tick count at which it happened; long_press fires on the
  // tick where HOLD_MS ticks have elapsed since then, and repeats fire on
  // every REPEAT_MS-th tick after the long press.
  int           gt;
  int           pre;
  logic [N-1:0] m_prev;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_held;
  int           press_at [N];
  int           lp_at    [N];

  always @(posedge clock) begin : model_blk
    logic [N-1:0] ep, er, el, eh, erp;
    bit tk, rise, fall;
    ep = '0; er = '0; el = '0; eh = '0; erp = '0;
    if (reset) begin
      pre    = 0;
      gt     = 0;
      m_prev = clean;
      m_pend = '0;
      m_held = '0;
    end else begin
      tk  = (pre == DIV - 1);
      pre = (pre + 1) % DIV;
      if (tk) gt++;
      for (int i = 0; i < N; i++) begin
        rise  = clean[i] && !m_prev[i];
        fall  = !clean[i] && m_prev[i];
        ep[i] = rise;
        er[i] = fall;
        if (fall) begin
          m_pend[i] = 1'b0;
          m_held[i] = 1'b0;
        end else if (rise) begin
          m_pend[i]   = 1'b1;
          press_at[i] = gt;
        end else if (tk && m_pend[i] && (gt - press_at[i]) == HOLD_MS) begin
          el[i]     = 1'b1;
          m_pend[i] = 1'b0;
          m_held[i] = 1'b1;
          lp_at[i]  = gt;
        end
`ifdef BUTTON_EVENT_REPEAT_EN
        else if (tk && m_held[i] && ((gt - lp_at[i]) % REPEAT_MS) == 0) begin
          erp[i] = 1'b1;
        end
`endif
        m_prev[i] = clean[i];
      end
      eh = m_held;
    end
    exp_q.push_back({ep, er, el, eh, erp});
  end

  // ---------------- driver tasks ----------------
  // Drive inputs, let one rising edge sample them, and land on the
  // following falling edge with the matching expected vector loaded.
  task automatic step(input logic [N-1:0] nxt, input logic rst);
    clean = nxt;
    reset = rst;
    @(negedge clock);
    cyc++;
    if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
    else exp_cur = 'x;
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(6'b000101, 1'b1);
      vectors++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=0", cyc, obs);
      end
    end
    for (int k = 0; k < 30; k++) begin
      step(6'b000101, 1'b0);
      vectors++;
      if ({pressed, released, long_press, held} !== '0) begin
        errors++;
        $display("FAIL reset_level_no_event cyc=%0d got=%h want=0", cyc,
                 {pressed, released, long_press, held});
      end
    end
    step('0, 1'b0);
    vectors++;
    if (obs !== exp_cur) begin
      errors++;
      $display("FAIL reset_release_drop cyc=%0d got=%h want=%h", cyc, obs, exp_cur);
    end
    settle(3);
  endtask

  task automatic test_press();
    int hits;
    hits = 0;
    step(6'b000001, 1'b0);
    vectors++;
    if (pressed !== 6'b000001 || {released, long_press, held, auto_repeat} !== '0) begin
      errors++;
      $display("FAIL press_first_cycle cyc=%0d got=%h want=%h", cyc, obs,
               {6'b000001, {(4*N){1'b0}}});
    end
    if (pressed[0]) hits++;
    for (int k = 0; k < 5; k++) begin
      step(6'b000001, 1'b0);
      if (pressed[0]) hits++;
      vectors++;
      if (obs !== exp_cur) begin
        errors++;
        $display("FAIL press_model cyc=%0d got=%h want=%h", cyc, obs, exp_cur);
      end
    end
    vectors++;
    if (hits !== 1) begin
      errors++;
      $display("FAIL press_pulse_width got=%0d want=1", hits);
    end
    settle(3);
  endtask

  task automatic test_long_press();
    int p_cyc, l_cyc, lp_cnt;
    p_cyc = -1; l_cyc = -1; lp_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      step(6'b001000, 1'b0);
      if (pressed[3] && p_cyc < 0) p_cyc = cyc;
      if (long_press[3]) begin
        lp_cnt++;
        l_cyc = cyc;
      end
      vectors++;
      if (obs !== exp_cur) begin
        errors++;
        $display("FAIL long_model cyc=%0d got=%h want=%h", cyc, obs, exp_cur);
      end
      if (l_cyc >= 0) begin
        vectors++;
        if (held[3] !== 1'b1) begin
          errors++;
          $display("FAIL long_held_level cyc=%0d got=%b want=1", cyc, held[3]);
        end
      end
    end
    vectors++;
    if (lp_cnt !== 1) begin
      errors++;
      $display("FAIL long_pulse_count got=%0d want=1", lp_cnt);
    end
    vectors++;
    if (p_cyc < 0 || (l_cyc - p_cyc) < 41 || (l_cyc - p_cyc) > 51) begin
      errors++;
      $display("FAIL long_latency got=%0d want=41..51", l_cyc - p_cyc);
    end
    step('0, 1'b0);
    vectors++;
    if (released[3] !== 1'b1) begin
      errors++;
      $display("FAIL long_release got=%b want=1", released[3]);
    end
    step('0, 1'b0);
    vectors++;
    if (held[3] !== 1'b0 || released[3] !== 1'b0) begin
      errors++;
      $display("FAIL long_held_clear got=%b%b want=00", held[3], released[3]);
    end
    settle(3);
  endtask

  task automatic test_short_hold();
    int p_cnt, r_cnt, l_cnt;
    p_cnt = 0; r_cnt = 0; l_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      step((k < 15) ? 6'b010000 : 6'b000000, 1'b0);
      p_cnt += int'(pressed[4]);
      r_cnt += int'(released[4]);
      l_cnt += int'(long_press[4]);
      vectors++;
      if (obs !== exp_cur) begin
        errors++;
        $display("FAIL short_model cyc=%0d got=%h want=%h", cyc, obs, exp_cur);
      end
    end
    vectors++;
    if (p_cnt !== 1 || r_cnt !== 1 || l_cnt !== 0) begin
      errors++;
      $display("FAIL short_counts got=p%0d r%0d l%0d want=p1 r1 l0", p_cnt, r_cnt, l_cnt);
    end
  endtask

  task automatic test_back_to_back();
    step(6'b000110, 1'b0);
    vectors++;
    if (pressed !== 6'b000110) begin
      errors++;
      $display("FAIL simul_press got=%b want=000110", pressed);
    end
    step(6'b100110, 1'b0);
    vectors++;
    if (pressed[5] !== 1'b1 || released[5] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_press got=%b%b want=10", pressed[5], released[5]);
    end
    step(6'b000110, 1'b0);
    vectors++;
    if (pressed[5] !== 1'b0 || released[5] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_release got=%b%b want=01", pressed[5], released[5]);
    end
    for (int k = 0; k < 60; k++) begin
      step(6'b000110, 1'b0);
      vectors++;
      if (long_press[5] !== 1'b0 || obs !== exp_cur) begin
        errors++;
        $display("FAIL glitch_model cyc=%0d got=%h want=%h", cyc, obs, exp_cur);
      end
    end
    settle(3);
  endtask

  task automatic test_reset_mid_hold();
    int p_cnt, l_cnt;
    p_cnt = 0; l_cnt = 0;
    for (int k = 0; k < 30; k++) step(6'b000001, 1'b0);
    for (int k = 0; k < 2; k++) step(6'b000001, 1'b1);
    for (int k = 0; k < 70; k++) begin
      step(6'b000001, 1'b0);
      p_cnt += int'(pressed[0]);
      l_cnt += int'(long_press[0]);
    end
    vectors++;
    if (p_cnt !== 0 || l_cnt !== 0) begin
      errors++;
      $display("FAIL midreset_events got=p%0d l%0d want=p0 l0", p_cnt, l_cnt);
    end
    step('0, 1'b0);
    vectors++;
    if (released[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_release got=%b want=1", released[0]);
    end
    settle(3);
  endtask

`ifdef BUTTON_EVENT_REPEAT_EN
  task automatic test_repeat();
    int l_cyc, next_rep, r_cnt;
    l_cyc = -1; next_rep = -1; r_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      step(6'b000001, 1'b0);
      if (long_press[0]) begin
        l_cyc    = cyc;
        next_rep = cyc + 20;
      end
      if (auto_repeat[0]) begin
        r_cnt++;
        vectors++;
        if (cyc !== next_rep) begin
          errors++;
          $display("FAIL repeat_spacing got=%0d want=%0d", cyc, next_rep);
        end
        next_rep = cyc + 20;
      end
      vectors++;
      if (obs !== exp_cur) begin
        errors++;
        $display("FAIL repeat_model cyc=%0d got=%h want=%h", cyc, obs, exp_cur);
      end
    end
    vectors++;
    if (l_cyc < 0 || r_cnt < 2) begin
      errors++;
      $display("FAIL repeat_count got=%0d want>=2", r_cnt);
    end
    settle(3);
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] lvl;
    logic         rst;
    lvl = '0;
    for (int k = 0; k < 1200; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 24) == 0) lvl[i] = ~lvl[i];
      end
      rst = ($urandom_range(0, 399) == 0);
      step(lvl, rst);
      vectors++;
      if (obs !== exp_cur) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, obs, exp_cur);
      end
    end
    settle(3);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_press();
    test_long_press();
    test_short_hold();
    test_back_to_back();
    test_reset_mid_hold();
`ifdef BUTTON_EVENT_REPEAT_EN
    test_repeat();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Hard stop in case a task ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
